// File: rtl/alu_divider_pkg.sv
// alu_divider_pkg: shared function codes, default width and divider state encoding
package alu_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [5:0] FC_ADD = 6'd32;
  localparam logic [5:0] FC_SUB = 6'd34;
  localparam logic [5:0] FC_AND = 6'd36;
  localparam logic [5:0] FC_OR = 6'd37;
  localparam logic [5:0] FC_SLT = 6'd42;
  localparam logic [5:0] FC_DIVU = 6'b011011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/alu_divider_div_step.sv
// alu_divider_div_step: one restoring shift-subtract step, shifted-out remainder bit kept as the carry bit
module alu_divider_div_step
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_trial;
  assign w_sh = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_sh - {1'b0, i_div};
  assign o_rem = w_trial[WIDTH] ? w_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
endmodule

// File: rtl/alu_divider.sv
// alu_divider: iterative unsigned divider, one quotient bit per clock, result {rem, quo}
module alu_divider
  import alu_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter logic [5:0] DIVU = FC_DIVU
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_zero
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] r_state;
  logic [CW-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_quo;
  alu_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_quo(r_quo),
    .i_div(r_div),
    .o_rem(w_rem),
    .o_quo(w_quo)
  );
  assign busy = r_state == S_RUN;
  assign done = r_state == S_DONE;
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      dataOut <= '0;
      div_zero <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (Signal == DIVU && dataB == '0) begin
        r_state <= S_DONE;
        dataOut <= {dataA, {WIDTH{1'b1}}};
        div_zero <= 1'b1;
      end else if (Signal == DIVU) begin
        r_state <= S_RUN;
        r_div <= dataB;
        r_rem <= '0;
        r_quo <= dataA;
        r_count <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem;
      r_quo <= w_quo;
      r_count <= r_count + 1'b1;
      if (r_count == CW'(WIDTH - 1)) begin
        dataOut <= {w_rem, w_quo};
        div_zero <= 1'b0;
        r_state <= S_DONE;
      end
    end else
      r_state <= S_IDLE;
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed vectors with hand-computed quotient, remainder and latency
module tb_alu_divider;
  import alu_divider_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic [5:0] Signal = '0;
  logic [63:0] dataOut;
  logic busy;
  logic done;
  logic div_zero;
  int n_tests = 0;
  int n_fail = 0;
  alu_divider dut (
    .clk(clk),
    .reset(reset),
    .dataA(dataA),
    .dataB(dataB),
    .Signal(Signal),
    .dataOut(dataOut),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dz,
                         input int lat_exp, input int poke_at);
    int lat;
    int nb;
    dataA = a;
    dataB = b;
    Signal = FC_DIVU;
    @(posedge clk);
    @(negedge clk);
    Signal = FC_ADD;
    dataA = 32'hDEAD_BEEF;
    dataB = 32'h0000_0003;
    lat = 1;
    nb = int'(busy);
    while (!done && lat < 100) begin
      if (lat == poke_at) begin
        Signal = FC_DIVU;
        dataA = 32'd50;
        dataB = 32'd5;
      end
      if (lat == poke_at + 3) Signal = FC_ADD;
      @(negedge clk);
      lat++;
      nb += int'(busy);
    end
    chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, " busy cycles"}, 64'(nb), 64'(lat_exp - 1));
    chk({tag, " dataOut"}, dataOut, {r, q});
    chk({tag, " div_zero"}, 64'(div_zero), 64'(dz));
    @(negedge clk);
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
  endtask
  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk("reset dataOut", dataOut, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 0);
    run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33, 0);
    run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, 0);
    run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 0);
    run_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
    run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);
    run_div("big divisor", 32'hC000_0001, 32'hC000_0000, 32'd1, 32'd1, 1'b0, 33, 0);
    run_div("max/8000_0001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 0);
    run_div("1000000/1000", 32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 33, 0);
    Signal = FC_ADD;
    dataA = 32'd40;
    dataB = 32'd2;
    repeat (3) @(negedge clk);
    chk("ADD no start busy", 64'(busy), 64'd0);
    chk("ADD no start done", 64'(done), 64'd0);
    chk("ADD no start dataOut", dataOut, {32'd0, 32'd1000});
    run_div("100/7 ignore DIVU", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10);
    dataA = 32'd100;
    dataB = 32'd7;
    Signal = FC_DIVU;
    @(posedge clk);
    @(negedge clk);
    Signal = FC_ADD;
    repeat (14) @(negedge clk);
    chk("mid-run busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort dataOut", dataOut, 64'd0);
    chk("abort div_zero", 64'(div_zero), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("abort no done", 64'(nd), 64'd0);
    run_div("20/6 after reset", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
